// File: rtl/rami_pkg.sv
// Shared definitions for the RAM burst initiator: FSM state encoding,
// skid-FIFO sizing and the default RAM geometry.
package rami_pkg;

  localparam int RAMI_AW = 8;  // default RAM address width
  localparam int RAMI_DW = 8;  // default RAM data width
  localparam int RAMI_LW = 8;  // default burst length field width

  // Read-return buffering: two entries cover the one-cycle RAM latency
  // plus one beat of consumer backpressure without bubbles.
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_PW    = $clog2(FIFO_DEPTH);
  localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } rami_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rami_skid_fifo.sv
// Two-entry skid FIFO for read data returning from the RAM. Push and pop
// may happen in the same cycle, including a push while full if a pop
// frees the slot in that same cycle.
module rami_skid_fifo
  import rami_pkg::*;
#(
  parameter int DW = RAMI_DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [DW-1:0]      din_i,
  input  logic               pop_i,
  output logic [DW-1:0]      dout_o,
  output logic [FIFO_CW-1:0] count_o
);

  logic [DW-1:0]      mem_q [FIFO_DEPTH];
  logic [FIFO_PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_CW-1:0] count_q, count_d;
  logic               do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FIFO_CW'(FIFO_DEPTH)) || do_pop);

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next pointer/count values from the push/pop pair.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + FIFO_PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + FIFO_PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + FIFO_CW'(1);
      2'b01:   count_d = count_q - FIFO_CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    // NOTE: the data array is left out of reset; occupancy is tracked by the
    // pointers/count, so stale contents are never observed and the array can
    // map onto plain flops or RAM cells without a reset network.
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ram_burst_initiator.sv
// Burst initiator for a single-port synchronous RAM with 1-cycle read
// latency. Commands arrive on a valid/ready port; write beats stream in and
// read beats stream out, each with full valid/ready backpressure.
// Optional build macro RAMI_BOUNDARY_CHECK_EN: bursts that would run past
// the top of the address space are accepted but rejected with an err pulse;
// without it addresses simply wrap and err stays 0.
module ram_burst_initiator
  import rami_pkg::*;
#(
  parameter int AW = RAMI_AW,
  parameter int DW = RAMI_DW,
  parameter int LW = RAMI_LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy,
  output logic          done,
  output logic          err
);

  rami_state_e        state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;           // next address to access
  logic [AW-1:0]      last_addr_q, last_addr_d; // last address driven to RAM
  logic [LW-1:0]      left_q, left_d;           // beats remaining minus one
  logic               inflight_q, inflight_d;   // read data due on ram_dout
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               wr_beat, rd_issue, rd_pop;
  logic               fifo_nonempty;
  logic [DW-1:0]      fifo_dout;
  logic [FIFO_CW-1:0] fifo_count;
  logic [FIFO_CW:0]   occupancy;
  logic               reject;

`ifdef RAMI_BOUNDARY_CHECK_EN
  localparam int SW = max_int(AW, LW) + 2;
  logic [SW-1:0] burst_end;
  assign burst_end = SW'(cmd_addr) + SW'(cmd_len) + SW'(1);
  assign reject    = (burst_end > SW'(2 ** AW));
`else
  assign reject    = 1'b0;
`endif

  rami_skid_fifo #(.DW(DW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .din_i   (ram_dout),
    .pop_i   (rd_pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count)
  );

  assign fifo_nonempty = (fifo_count != '0);
  assign rd_pop        = rd_valid && rd_ready;
  assign wr_beat       = !rst && (state_q == WRITE) && wr_valid;

  // Slots committed after this cycle: buffered + arriving - leaving. Counting
  // the pop lets a new address go out every cycle while the consumer keeps up.
  assign occupancy = {1'b0, fifo_count} + (FIFO_CW + 1)'(inflight_q)
                   - (FIFO_CW + 1)'(rd_pop);
  assign rd_issue  = !rst && (state_q == READ)
                   && (occupancy < (FIFO_CW + 1)'(FIFO_DEPTH));

  // Outputs are forced low while rst is high.
  assign cmd_ready = !rst && (state_q == IDLE);
  assign wr_ready  = !rst && (state_q == WRITE);
  assign rd_valid  = !rst && fifo_nonempty;
  assign rd_data   = rd_valid ? fifo_dout : '0;
  assign ram_we    = wr_beat;
  assign ram_din   = wr_beat ? wr_data : '0;
  assign ram_addr  = rst ? '0 : ((wr_beat || rd_issue) ? addr_q : last_addr_q);
  assign busy      = !rst && (state_q != IDLE);
  assign done      = !rst && done_q;
  assign err       = !rst && err_q;

  // Next-state: command capture, per-beat address/length stepping, drain.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    left_d      = left_q;
    inflight_d  = rd_issue;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          left_d = cmd_len;
          if (reject)         err_d   = 1'b1;
          else if (cmd_write) state_d = WRITE;
          else                state_d = READ;
        end
      end
      WRITE: begin
        if (wr_beat) begin
          addr_d      = addr_q + AW'(1);
          last_addr_d = addr_q;
          if (left_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            left_d = left_q - LW'(1);
          end
        end
      end
      READ: begin
        if (rd_issue) begin
          addr_d      = addr_q + AW'(1);
          last_addr_d = addr_q;
          if (left_q == '0) state_d = DRAIN;
          else              left_d  = left_q - LW'(1);
        end
      end
      DRAIN: begin
        // Last beat leaves the FIFO with nothing behind it.
        if (rd_pop && (fifo_count == FIFO_CW'(1)) && !inflight_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any burst in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      last_addr_q <= '0;
      left_q      <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      left_q      <= left_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule
